ou_arbiter: RTL and testbench
=============================

# ou_arbiter

Round-robin arbiter and sequencer that shares one registered bitwise-OR evaluation unit (S = A | B) among N requesters. Each requester presents its own operand pair and a request. The block grants one requester at a time, captures its operands, evaluates the OR and returns the result tagged with the requester index. It sits between the requester blocks and the single shared OR datapath.

## Interface
- N_REQ, 4: number of requesters, 2..8.
- W, 1: operand/result width in bits (bitwise OR).

- clk  in  1  sole clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req  in  N_REQ  per-requester request, level.
- a  in  N_REQ*W  operand A; requester i occupies bits [i*W +: W].
- b  in  N_REQ*W  operand B; same packing as a.
- gnt  out  N_REQ  one-hot grant pulse, registered.
- s  out  W  result A|B of the granted requester, registered.
- s_valid  out  1  one-cycle pulse; s and s_id are valid.
- s_id  out  max(1,$clog2(N_REQ))  index of the requester that owns s.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states are IDLE, EVAL and RESP.
- IDLE: if req is non-zero, pick the first set bit searching upward from ptr+1 modulo N_REQ. Register gnt as a one-hot of the winner. Capture a/b slices into op_a/op_b. Store the winner in cur_id and go to EVAL. If req is zero, stay in IDLE.
- EVAL: s <= op_a | op_b. s_id <= cur_id. gnt <= 0. Go to RESP.
- RESP: s_valid = 1. ptr <= cur_id. Go to IDLE.
- Operands are sampled only at the IDLE→EVAL edge. Later changes on a/b do not affect the result.
- Handshake: a requester holds req and its operands stable until it sees gnt. If req is still high in the cycle after s_valid, that counts as a new request.
- s holds its value between results. s_valid and gnt are pulses.
- Reset values: state=IDLE, gnt=0, s=0, s_valid=0, s_id=0, busy=0, ptr=N_REQ-1 (requester 0 has first priority), lock_cnt=0.
- If rst_n is sampled low mid-operation, the FSM returns to IDLE. The pending operation is dropped and no s_valid is produced.

## Timing
- req sampled high at edge t in IDLE:
  - gnt is high during cycle t+1.
  - s_valid is high during cycle t+2.
  - Arbitration for the next operation happens at edge t+3.
- Throughput is one operation per 3 cycles per arbiter.
- Simultaneous requests are resolved purely by the round-robin order. Any continuously requesting requester waits at most N_REQ-1 operations.
- Pointer wrap: a winner at N_REQ-1 makes requester 0 the highest priority next.

## Configuration
- OU_ARB_LOCK_EN defined:
  - Adds input lock [N_REQ].
  - In RESP, if lock[cur_id] && req[cur_id] && lock_cnt < LOCK_MAX, the FSM goes directly to EVAL with the same cur_id. Operands are recaptured, gnt pulses again, ptr is unchanged and lock_cnt is incremented.
  - Otherwise the block behaves as normal and lock_cnt is cleared.
  - Back-to-back throughput under lock is one operation per 2 cycles.
- OU_ARB_LOCK_EN not defined: there is no lock port and the FSM is pure round-robin, as described above.

## Structure
- Package ou_arb_pkg holds:
  - the state enum (IDLE, EVAL, RESP);
  - LOCK_MAX = 4;
  - a function returning the index of the next set bit after a pointer.
- Sub-module ou_arb_rr_pick: combinational round-robin picker. Inputs are req and ptr; outputs are winner index and any_req. It is instantiated once.

## Test plan
- Single request: after reset, req=0100, a/b slice 2 = 1/0 with W=1 → gnt=0100 at t+1; s=1, s_id=2, s_valid at t+2; busy high t+1..t+2.
- All four requesters held high → grant order 0,1,2,3,0; each s_id matches; s_valid pulses spaced exactly 3 cycles apart.
- Truth table via requester 1 with W=1, operands 00/01/10/11 → s = 0/1/1/1.
- Operand change after gnt: W=4, a=0x1, b=0x2 captured, a changed to 0xF in EVAL → s=0x3.
- Reset mid-EVAL: rst_n low for one edge → next cycle gnt=0, s_valid=0, s=0, busy=0; the next request is served with requester 0 first.
- OU_ARB_LOCK_EN: req=1001 with lock[0]=1 → requester 0 is granted 5 times back to back (1 + LOCK_MAX), then requester 3.

Source files
------------

// File: rtl/ou_arb_pkg.sv
// Shared types and helpers for the ou_arbiter round-robin OR-unit sequencer.
// The optional lock feature is enabled by defining OU_ARB_LOCK_EN.
package ou_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EVAL = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int LOCK_MAX   = 4;
   localparam int LOCK_CNT_W = $clog2(LOCK_MAX + 1);
   localparam int MAX_REQ    = 8;

   // First set bit strictly after ptr, searching upward modulo n; returns ptr if none.
   function automatic int next_set(input logic [MAX_REQ-1:0] req, input int ptr, input int n);
      int         win;
      logic [2:0] idx;
      win = ptr;
      for (int k = MAX_REQ; k >= 1; k--) begin
         if (k <= n) begin
            idx = 3'((ptr + k) % n);
            if (req[idx]) win = int'(idx);
         end
      end
      return win;
   endfunction

endpackage

// File: rtl/ou_arb_rr_pick.sv
// Combinational round-robin picker: the winner is the first requester after ptr.
module ou_arb_rr_pick
   import ou_arb_pkg::*;
#(
   parameter  int N_REQ = 4,
   localparam int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IW-1:0]    ptr,
   output logic [IW-1:0]    winner,
   output logic             any_req
);

   always_comb begin
      winner = IW'(next_set(MAX_REQ'(req), int'(ptr), N_REQ));
   end

   assign any_req = |req;

endmodule

// File: rtl/ou_arbiter.sv
// Round-robin arbiter sharing one registered OR unit (s = a | b) among N_REQ requesters.
// Define OU_ARB_LOCK_EN to add the lock input that lets a requester keep the unit.
module ou_arbiter
   import ou_arb_pkg::*;
#(
   parameter  int N_REQ = 4,
   parameter  int W     = 1,
   localparam int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N_REQ-1:0]   req,
   input  logic [N_REQ*W-1:0] a,
   input  logic [N_REQ*W-1:0] b,
`ifdef OU_ARB_LOCK_EN
   input  logic [N_REQ-1:0]   lock,
`endif
   output logic [N_REQ-1:0]   gnt,
   output logic [W-1:0]       s,
   output logic               s_valid,
   output logic [IW-1:0]      s_id,
   output logic               busy
);

   state_t          state, state_nxt;
   logic [IW-1:0]   ptr, cur_id, winner, cap_id;
   logic            any_req, capture, lock_hit;
   logic [W-1:0]    op_a, op_b;
`ifdef OU_ARB_LOCK_EN
   logic [LOCK_CNT_W-1:0] lock_cnt;
`endif

   ou_arb_rr_pick #(.N_REQ(N_REQ)) u_pick (
      .req     (req),
      .ptr     (ptr),
      .winner  (winner),
      .any_req (any_req)
   );

   always_comb begin
      lock_hit = 1'b0;
`ifdef OU_ARB_LOCK_EN
      lock_hit = lock[cur_id] && req[cur_id] && (lock_cnt < LOCK_CNT_W'(LOCK_MAX));
`endif
   end

   // NOTE: every always_comb output is given a default first so no latch is inferred.
   always_comb begin
      state_nxt = state;
      capture   = 1'b0;
      cap_id    = winner;
      unique case (state)
         IDLE: if (any_req) begin
            state_nxt = EVAL;
            capture   = 1'b1;
         end
         EVAL: state_nxt = RESP;
         RESP: if (lock_hit) begin
            state_nxt = EVAL;
            capture   = 1'b1;
            cap_id    = cur_id;
         end else begin
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         gnt      <= '0;
         s        <= '0;
         s_id     <= '0;
         cur_id   <= '0;
         ptr      <= IW'(N_REQ - 1);
`ifdef OU_ARB_LOCK_EN
         lock_cnt <= '0;
`endif
      end else begin
         gnt <= '0;
         if (capture) begin
            gnt[cap_id] <= 1'b1;
            cur_id      <= cap_id;
         end
         if (state == EVAL) begin
            s    <= op_a | op_b;
            s_id <= cur_id;
         end
         if (state == RESP) begin
`ifdef OU_ARB_LOCK_EN
            if (lock_hit) begin
               lock_cnt <= lock_cnt + 1'b1;
            end else begin
               ptr      <= cur_id;
               lock_cnt <= '0;
            end
`else
            ptr <= cur_id;
`endif
         end
      end
   end

   // NOTE: operand registers carry no reset; they are always loaded before EVAL reads them.
   always_ff @(posedge clk) begin
      if (capture) begin
         op_a <= a[cap_id*W +: W];
         op_b <= b[cap_id*W +: W];
      end
   end

   assign s_valid = (state == RESP);
   assign busy    = (state != IDLE);

endmodule

// File: tb/tb_ou_arbiter.sv
// Directed self-checking bench for ou_arbiter with N_REQ=4, W=4.
// Lock scenarios run only when OU_ARB_LOCK_EN is defined.
module tb_ou_arbiter;

   localparam int N = 4;
   localparam int W = 4;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [N-1:0]   req;
   logic [N*W-1:0] a, b;
   logic [N-1:0]   gnt;
   logic [W-1:0]   s;
   logic           s_valid;
   logic [1:0]     s_id;
   logic           busy;
`ifdef OU_ARB_LOCK_EN
   logic [N-1:0]   lock;
`endif

   int n_vec = 0;
   int n_err = 0;

   ou_arbiter #(.N_REQ(N), .W(W)) u_dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .a       (a),
      .b       (b),
`ifdef OU_ARB_LOCK_EN
      .lock    (lock),
`endif
      .gnt     (gnt),
      .s       (s),
      .s_valid (s_valid),
      .s_id    (s_id),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One full operation with req released after the grant is seen.
   task automatic do_op(input string tag, input logic [N-1:0] r, input logic [N*W-1:0] av,
                        input logic [N*W-1:0] bv, input int id, input logic [W-1:0] sv);
      req = r; a = av; b = bv;
      step();
      check({tag, "_gnt"}, 32'(gnt), 32'(1 << id));
      check({tag, "_busy1"}, 32'(busy), 32'h1);
      check({tag, "_sv_early"}, 32'(s_valid), 32'h0);
      req = '0;
      step();
      check({tag, "_sv"}, 32'(s_valid), 32'h1);
      check({tag, "_sid"}, 32'(s_id), 32'(id));
      check({tag, "_s"}, 32'(s), 32'(sv));
      check({tag, "_busy2"}, 32'(busy), 32'h1);
      check({tag, "_gnt_clr"}, 32'(gnt), 32'h0);
      step();
      check({tag, "_sv_end"}, 32'(s_valid), 32'h0);
      check({tag, "_idle"}, 32'(busy), 32'h0);
      check({tag, "_s_hold"}, 32'(s), 32'(sv));
   endtask

   initial begin
      rst_n = 1'b0; req = '0; a = '0; b = '0;
`ifdef OU_ARB_LOCK_EN
      lock = '0;
`endif
      step();
      step();
      check("rst_gnt", 32'(gnt), 32'h0);
      check("rst_s", 32'(s), 32'h0);
      check("rst_sv", 32'(s_valid), 32'h0);
      check("rst_sid", 32'(s_id), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      rst_n = 1'b1;

      // Single request from requester 2, a=1 b=0.
      do_op("single", 4'b0100, 16'h0100, 16'h0000, 2, 4'h1);

      // Re-reset so requester 0 has first priority, then hold all four requests.
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      req = 4'b1111; a = 16'h8421; b = 16'h0000;
      for (int k = 0; k < 5; k++) begin
         step();
         check($sformatf("rr%0d_gnt", k), 32'(gnt), 32'(1 << (k % N)));
         step();
         check($sformatf("rr%0d_sv", k), 32'(s_valid), 32'h1);
         check($sformatf("rr%0d_sid", k), 32'(s_id), 32'(k % N));
         check($sformatf("rr%0d_s", k), 32'(s), 32'(1 << (k % N)));
         step();
         check($sformatf("rr%0d_gap", k), 32'(s_valid), 32'h0);
      end
      req = '0;
      step();

      // OR truth table through requester 1: bits cover 00/01/10/11.
      do_op("tt", 4'b0010, 16'h0030, 16'h0050, 1, 4'h7);
      do_op("tt_zero", 4'b0010, 16'h0000, 16'h0000, 1, 4'h0);

      // Operand change after the grant must not affect the result.
      req = 4'b0100; a = 16'h0100; b = 16'h0200;
      step();
      check("opchg_gnt", 32'(gnt), 32'h4);
      a = 16'h0F00; req = '0;
      step();
      check("opchg_sv", 32'(s_valid), 32'h1);
      check("opchg_s", 32'(s), 32'h3);
      check("opchg_sid", 32'(s_id), 32'h2);
      step();

      // Reset while in EVAL drops the operation.
      req = 4'b1000; a = 16'h5000; b = 16'h0000;
      step();
      check("mid_gnt", 32'(gnt), 32'h8);
      rst_n = 1'b0; req = '0;
      step();
      check("mid_rst_gnt", 32'(gnt), 32'h0);
      check("mid_rst_sv", 32'(s_valid), 32'h0);
      check("mid_rst_s", 32'(s), 32'h0);
      check("mid_rst_sid", 32'(s_id), 32'h0);
      check("mid_rst_busy", 32'(busy), 32'h0);
      rst_n = 1'b1;
      req = 4'b1111; a = 16'h8421;
      step();
      check("post_rst_gnt", 32'(gnt), 32'h1);
      check("post_rst_nosv", 32'(s_valid), 32'h0);
      req = '0;
      step();
      check("post_rst_sv", 32'(s_valid), 32'h1);
      check("post_rst_sid", 32'(s_id), 32'h0);
      check("post_rst_s", 32'(s), 32'h1);
      step();

`ifdef OU_ARB_LOCK_EN
      // Locked requester 0 keeps the unit for 1 + LOCK_MAX operations, then 3 is served.
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      req = 4'b1001; lock = 4'b0001; a = 16'h8001; b = 16'h0000;
      step();
      for (int k = 0; k < 5; k++) begin
         check($sformatf("lock%0d_gnt", k), 32'(gnt), 32'h1);
         step();
         check($sformatf("lock%0d_sv", k), 32'(s_valid), 32'h1);
         check($sformatf("lock%0d_sid", k), 32'(s_id), 32'h0);
         step();
      end
      check("lock_release_idle", 32'(busy), 32'h0);
      step();
      check("lock_next_gnt", 32'(gnt), 32'h8);
      req = '0; lock = '0;
      step();
      check("lock_next_sid", 32'(s_id), 32'h3);
      check("lock_next_s", 32'(s), 32'h8);
      step();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
